picomem_sram_param: RTL and testbench

PICOMEM_SRAM_PARAM -- requirements
Module: picomem_sram_param

---
 rtl/picomem_sram_param.sv | 153 +++++++++++++++
 tb/tb_picomem_sram_param.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/picomem_sram_param.sv
`default_nettype none
// ============================================================================
// Module      : picomem_sram_param
// Description : Word-addressed 32-bit SRAM slave on a valid/ready memory bus.
//               It has a programmable number of wait states, byte-lane writes
//               and write-first read data.
//               Optional macro PICOMEM_RANGE_CHECK_EN: when it is defined,
//               accesses whose upper address bits do not match BASE_ADDR
//               complete with an error. When it is undefined, they alias.
// Revision    : 1.0 - initial release
// ============================================================================
module picomem_sram_param #(
    parameter int          ADDR_WIDTH  = 11,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_s_valid,
    input  logic [31:0] mem_s_addr,
    input  logic [31:0] mem_s_wdata,
    input  logic [3:0]  mem_s_wstrb,
    output logic        mem_s_ready,
    output logic [31:0] mem_s_rdata,
    output logic        mem_s_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // The counter is loaded with one less than the wait count and counts down to zero.
    localparam logic [3:0] c_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam bit         c_NO_WAIT   = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_ready;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_mem [0:DEPTH-1];

    logic                  w_from_inputs;
    logic [31:0]           w_addr;
    logic [31:0]           w_wdata;
    logic [3:0]            w_wstrb;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [31:0]           w_merged;
    logic                  w_enter_resp;
    logic                  w_oor;
    logic                  w_we;

    // With no wait states the access completes on the accepting edge.
    // In that case the live bus inputs feed the datapath.
    // In every other case the captured copies feed it.
    assign w_from_inputs = (r_state == ST_IDLE);
    assign w_addr        = w_from_inputs ? mem_s_addr  : r_addr;
    assign w_wdata       = w_from_inputs ? mem_s_wdata : r_wdata;
    assign w_wstrb       = w_from_inputs ? mem_s_wstrb : r_wstrb;
    assign w_idx         = w_addr[ADDR_WIDTH+1:2];

    assign w_enter_resp = ((r_state == ST_IDLE) && mem_s_valid && c_NO_WAIT) ||
                          ((r_state == ST_WAIT) && (r_cnt == 4'd0));

`ifdef PICOMEM_RANGE_CHECK_EN
    assign w_oor = (w_addr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]);
    logic w_unused;
    assign w_unused = &{1'b0, w_addr[1:0]};
`else
    assign w_oor = 1'b0;
    logic w_unused;
    assign w_unused = &{1'b0, w_addr[31:ADDR_WIDTH+2], w_addr[1:0], BASE_ADDR};
`endif

    assign w_we = w_enter_resp && !w_oor && (|w_wstrb);

    // Merge the enabled write lanes over the stored word, which gives write-first read data.
    always_comb begin
        w_merged = r_mem[w_idx];
        for (int i = 0; i < 4; i++) begin
            if (w_wstrb[i]) begin
                w_merged[8*i +: 8] = w_wdata[8*i +: 8];
            end
        end
    end

    // Storage array. There is no reset, and no write happens on an edge while reset is held.
    always_ff @(posedge clk) begin
        if (resetn && w_we) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    // Control FSM. It captures the request, counts the wait states and registers the response.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (mem_s_valid) begin
                        r_addr  <= mem_s_addr;
                        r_wdata <= mem_s_wdata;
                        r_wstrb <= mem_s_wstrb;
                        if (c_NO_WAIT) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= c_WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            if (w_enter_resp) begin
                r_ready <= 1'b1;
                r_err   <= w_oor;
                r_rdata <= w_oor ? 32'd0 : w_merged;
            end
        end
    end

    assign mem_s_ready = r_ready;
    assign mem_s_err   = r_err;
    assign mem_s_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_picomem_sram_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_picomem_sram_param
// Description : Self-checking bench. It drives two SRAM instances: one with
//               0 wait states and one with 3. Results are checked against a
//               word-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_picomem_sram_param;

    localparam int AW = 11;
    localparam int c_WS0 = 0;
    localparam int c_WS1 = 3;
`ifdef PICOMEM_RANGE_CHECK_EN
    localparam bit c_RC = 1'b1;
`else
    localparam bit c_RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn [2];
    logic        v    [2];
    logic [31:0] a    [2];
    logic [31:0] wd   [2];
    logic [3:0]  st   [2];
    logic        rdy  [2];
    logic [31:0] rd   [2];
    logic        er   [2];

    logic [31:0] mdl [2][2048];
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    picomem_sram_param #(.ADDR_WIDTH(AW), .WAIT_STATES(c_WS0), .BASE_ADDR(32'h0)) u_dut0 (
        .clk(clk), .resetn(rstn[0]), .mem_s_valid(v[0]), .mem_s_addr(a[0]),
        .mem_s_wdata(wd[0]), .mem_s_wstrb(st[0]), .mem_s_ready(rdy[0]),
        .mem_s_rdata(rd[0]), .mem_s_err(er[0]));

    picomem_sram_param #(.ADDR_WIDTH(AW), .WAIT_STATES(c_WS1), .BASE_ADDR(32'h0)) u_dut1 (
        .clk(clk), .resetn(rstn[1]), .mem_s_valid(v[1]), .mem_s_addr(a[1]),
        .mem_s_wdata(wd[1]), .mem_s_wstrb(st[1]), .mem_s_ready(rdy[1]),
        .mem_s_rdata(rd[1]), .mem_s_err(er[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_assert++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, req);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Runs one bus transaction on instance d and checks it against the model.
    // The inputs are scrambled after acceptance, and valid may be dropped early.
    task automatic xact(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input bit drop, output logic [31:0] got);
        int          idx;
        bit          oor;
        logic [31:0] req;
        int          n;
        bit          seen;
        int          ws;
        ws  = (d == 0) ? c_WS0 : c_WS1;
        idx = int'((addr >> 2) % 2048);
        oor = c_RC && ((addr >> (AW + 2)) != 0);
        req = oor ? 32'd0 : merge(mdl[d][idx], wdata, strb);
        if (!oor && strb != 4'd0) mdl[d][idx] = req;
        @(negedge clk);
        v[d] = 1'b1; a[d] = addr; wd[d] = wdata; st[d] = strb;
        @(posedge clk);
        n = 1;
        #1;
        a[d] = $urandom; wd[d] = $urandom; st[d] = 4'($urandom);
        if (drop) v[d] = 1'b0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            if (rdy[d]) seen = 1'b1;
            else begin
                @(posedge clk);
                n++;
                #1;
            end
        end
        chk("ready_seen", 32'(seen), 32'd1);
        chk("latency", n, 1 + ws);
        chk("rdata", rd[d], req);
        chk("err", 32'(er[d]), 32'(oor));
        got = rd[d];
        @(posedge clk);
        #1;
        v[d] = 1'b0;
        chk("ready_single_pulse", 32'(rdy[d]), 32'd0);
        chk("err_outside_resp", 32'(er[d]), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        int          first, gap, npulse, last;
        int          pool [16];

        for (int d = 0; d < 2; d++) begin
            rstn[d] = 1'b0; v[d] = 1'b0; a[d] = '0; wd[d] = '0; st[d] = '0;
        end
        for (int i = 0; i < 8; i++) begin
            pool[i]     = i;
            pool[i + 8] = 2040 + i;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", 32'(rdy[d]), 32'd0);
            chk("reset_err", 32'(er[d]), 32'd0);
            chk("reset_rdata", rd[d], 32'd0);
        end
        @(negedge clk);
        rstn[0] = 1'b1; rstn[1] = 1'b1;

        // Preload the address pool so every later read has a known value.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++)
                xact(d, 32'(pool[i]) << 2, $urandom, 4'hF, 1'b0, got);

        // Full-word write and readback with no wait states.
        xact(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, got);
        xact(0, 32'h10, 32'h0, 4'h0, 1'b0, got);
        chk("deadbeef_read", got, 32'hDEADBEEF);

        // Byte-lane merge.
        xact(0, 32'h20, 32'h11223344, 4'hF, 1'b0, got);
        xact(0, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, got);
        chk("lane_write_first", got, 32'h11BB33DD);
        xact(0, 32'h20, 32'h0, 4'h0, 1'b0, got);
        chk("lane_read", got, 32'h11BB33DD);

        // Three wait states with valid held continuously: ready at edge 4, next ready 5 edges later.
        @(negedge clk);
        v[1] = 1'b1; a[1] = 32'h0; wd[1] = 32'h0; st[1] = 4'h0;
        first = 0; gap = 0; npulse = 0; last = 0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if (rdy[1]) begin
                npulse++;
                if (npulse == 1) first = e;
                else gap = e - last;
                last = e;
            end
        end
        v[1] = 1'b0;
        chk("held_first_ready_edge", first, 4);
        chk("held_ready_spacing", gap, 5);
        repeat (3) @(posedge clk);

        // A reset one cycle into a waited write aborts it.
        xact(1, 32'h40, 32'h12345678, 4'hF, 1'b0, got);
        @(negedge clk);
        v[1] = 1'b1; a[1] = 32'h40; wd[1] = 32'h55; st[1] = 4'hF;
        @(posedge clk);
        #1;
        v[1] = 1'b0;
        @(negedge clk);
        rstn[1] = 1'b0;
        @(posedge clk);
        #1;
        rstn[1] = 1'b1;
        chk("midreset_rdata", rd[1], 32'd0);
        npulse = 0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk);
            #1;
            if (rdy[1]) npulse++;
        end
        chk("midreset_no_ready", npulse, 0);
        xact(1, 32'h40, 32'h0, 4'h0, 1'b0, got);
        chk("midreset_prior_value", got, 32'h12345678);

        // Out-of-range access: an error when range checking is built in, otherwise it aliases to word 0.
        xact(0, 32'h0, 32'h0BADC0DE, 4'hF, 1'b0, got);
        xact(0, 32'h2000, 32'hCAFEF00D, 4'hF, 1'b0, got);
        xact(0, 32'h0, 32'h0, 4'h0, 1'b0, got);
        chk("range_word0", got, c_RC ? 32'h0BADC0DE : 32'hCAFEF00D);

        // Last word of the array.
        xact(0, 32'h1FFC, 32'hA5A5_5A5A, 4'hF, 1'b0, got);
        xact(0, 32'h1FFC, 32'h0, 4'h0, 1'b0, got);
        chk("last_word", got, 32'hA5A5_5A5A);
        xact(0, 32'h0, 32'h0, 4'h0, 1'b0, got);
        chk("word0_untouched", got, c_RC ? 32'h0BADC0DE : 32'hCAFEF00D);

        // Random traffic over the pool, with occasional high address bits and early valid drops.
        for (int k = 0; k < 80; k++) begin
            int          d;
            logic [31:0] addr;
            d    = int'($urandom_range(0, 1));
            addr = (32'(pool[$urandom_range(0, 15)]) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) addr = addr | (32'($urandom_range(1, 7)) << (AW + 2));
            xact(d, addr, $urandom, 4'($urandom), 1'($urandom), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
